// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle CPU control FSM; define RETIRE_CNT_EN to add the retired-instruction counter
//
// Opcode map (opcode[4:0]):
//   00000 ALU reg   functionCode 00 ADD, 01 ADC, 10 SUB, 11 SBB
//   00001 CMP       00100 ADDI   00101 SUBI   00110 MOV
//   01000 LHI       01001 LLI    10000 LDR    10001 STR
//   11000 Bcond     branchFunc 00 BEQ, 01 BNE, 10 BCS, 11 BCC
//   11001 B[AL]     11010 JMP    11011 JAL label
//   11100 OutR (functionCode 00) / HLT (others)
//   11101 JAL Rd Rm 11110 JR     anything else executes as a NOP
// The first cycle after a reset edge is a quiet FETCH with every output low;
// memReq rises on the cycle after that.
module multicycle_controller #(
  parameter int LENGTH = 16,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic [1:0] functionCode,
  input  logic [1:0] branchFunc,
  input  logic [3:0] NZCV,
  input  logic       memReady,
  input  logic       outAck,
  output logic       memReq,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       flagWrite,
  output logic [1:0] pcSel,
  output logic       regWrite,
  output logic       writeMem,
  output logic       jal,
  output logic       mem2Reg,
  output logic       aluSrcB,
  output logic [2:0] aluOpcode,
  output logic       outR,
  output logic       hlt,
  output logic [2:0] state
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retired
`endif
);
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, OUT = 3'd5, HALT = 3'd6
  } state_t;
  localparam logic [2:0] A_LHI = 3'd0, A_LLI = 3'd1, A_ADD = 3'd2, A_SUB = 3'd4, A_MOV = 3'd6;
  localparam logic [1:0] PC_PLUS = 2'd0, PC_BRANCH = 2'd1, PC_LABEL = 2'd2, PC_RM = 2'd3;
  localparam logic [4:0] OP_ALU = 5'b00000, OP_CMP = 5'b00001, OP_ADDI = 5'b00100,
    OP_SUBI = 5'b00101, OP_MOV = 5'b00110, OP_LHI = 5'b01000, OP_LLI = 5'b01001,
    OP_LDR = 5'b10000, OP_STR = 5'b10001, OP_BCC = 5'b11000, OP_BAL = 5'b11001,
    OP_JMP = 5'b11010, OP_JAL = 5'b11011, OP_SYS = 5'b11100, OP_JALR = 5'b11101,
    OP_JR = 5'b11110;
  state_t state_q, state_d;
  logic run_q, run_d;
  logic is_alu, op_b, op_flag, taken;
  logic [2:0] op_alu;
  logic unused_ok;
  assign unused_ok = ^{NZCV[3], NZCV[0]} ^ (LENGTH > 0) ^ (CNT_W > 0);
  assign state = state_q;
  assign run_d = 1'b1;
  assign taken = (opcode == OP_BAL) | ((opcode == OP_BCC) &
    (branchFunc == 2'd0 ? NZCV[2] : branchFunc == 2'd1 ? !NZCV[2] :
     branchFunc == 2'd2 ? NZCV[1] : !NZCV[1]));
  // ALU-class decode, shared by EXEC and the register write-back that follows it
  always_comb begin
    is_alu = 1'b1;
    op_alu = A_ADD;
    op_b = 1'b0;
    op_flag = 1'b0;
    case (opcode)
      OP_ALU:  begin op_alu = {1'b0, functionCode} + 3'd2; op_flag = 1'b1; end
      OP_ADDI: begin op_alu = A_ADD; op_b = 1'b1; op_flag = 1'b1; end
      OP_SUBI: begin op_alu = A_SUB; op_b = 1'b1; op_flag = 1'b1; end
      OP_MOV:  op_alu = A_MOV;
      OP_LHI:  begin op_alu = A_LHI; op_b = 1'b1; end
      OP_LLI:  begin op_alu = A_LLI; op_b = 1'b1; end
      default: is_alu = 1'b0;
    endcase
  end
  // next state and control outputs for the current state
  always_comb begin
    state_d = state_q;
    memReq = 1'b0;
    irWrite = 1'b0;
    pcWrite = 1'b0;
    flagWrite = 1'b0;
    pcSel = PC_PLUS;
    regWrite = 1'b0;
    writeMem = 1'b0;
    jal = 1'b0;
    mem2Reg = 1'b0;
    aluSrcB = 1'b0;
    aluOpcode = A_LHI;
    outR = 1'b0;
    hlt = 1'b0;
    case (state_q)
      FETCH: if (run_q) begin
        memReq = 1'b1;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        state_d = FETCH;
        if (is_alu) begin
          aluOpcode = op_alu;
          aluSrcB = op_b;
          flagWrite = op_flag;
          state_d = WB;
        end else case (opcode)
          OP_CMP: begin aluOpcode = A_SUB; flagWrite = 1'b1; end
          OP_LDR, OP_STR: begin aluSrcB = 1'b1; aluOpcode = A_ADD; state_d = MEM; end
          OP_BCC, OP_BAL: if (taken) begin pcWrite = 1'b1; pcSel = PC_BRANCH; aluSrcB = 1'b1; end
          OP_JMP: begin pcWrite = 1'b1; pcSel = PC_LABEL; end
          OP_JAL: begin jal = 1'b1; regWrite = 1'b1; aluSrcB = 1'b1; pcWrite = 1'b1; pcSel = PC_BRANCH; end
          OP_JALR: begin jal = 1'b1; regWrite = 1'b1; pcWrite = 1'b1; pcSel = PC_RM; end
          OP_JR: begin pcWrite = 1'b1; pcSel = PC_RM; end
          OP_SYS: state_d = functionCode == 2'd0 ? OUT : HALT;
          default: ;
        endcase
      end
      MEM: begin
        memReq = 1'b1;
        aluSrcB = 1'b1;
        aluOpcode = A_ADD;
        writeMem = opcode == OP_STR;
        if (memReady) state_d = opcode == OP_STR ? FETCH : WB;
      end
      WB: begin
        regWrite = 1'b1;
        mem2Reg = opcode == OP_LDR;
        aluOpcode = is_alu ? op_alu : A_ADD;
        aluSrcB = is_alu ? op_b : 1'b1;
        state_d = FETCH;
      end
      OUT: begin
        outR = 1'b1;
        if (outAck) state_d = FETCH;
      end
      HALT: hlt = 1'b1;
      default: state_d = FETCH;
    endcase
  end
  // state register; reset lands in a quiet FETCH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
    end
  end
`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;
  assign retired = retired_q;
  // one count per instruction that completes back into FETCH
  always_comb retired_d = retired_q + CNT_W'(state_d == FETCH && state_q inside {EXEC, MEM, WB, OUT});
  // retired counter register
  always_ff @(posedge clk) begin
    if (!rst_n) retired_q <= '0;
    else retired_q <= retired_d;
  end
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized cycle-level check of the control FSM against a per-instruction plan
module tb_multicycle_controller;
  typedef struct packed {
    logic mem_req, ir_write, pc_write, flag_write;
    logic [1:0] pc_sel;
    logic reg_write, write_mem, jal, mem2reg, alu_b;
    logic [2:0] alu_op;
    logic out_r, hlt;
  } outs_t;
  typedef struct packed {
    logic mr, ack;
    logic [2:0] st;
    outs_t o;
    logic [3:0] ret;
  } ent_t;
  localparam logic [2:0] S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4, S_O = 5, S_H = 6;
  localparam logic [4:0] LDR = 5'b10000, STR = 5'b10001, BCC = 5'b11000, BAL = 5'b11001,
    JMP = 5'b11010, JAL = 5'b11011, SYS = 5'b11100, JALR = 5'b11101, JR = 5'b11110, NOP = 5'b11111;
  logic clk = 0, rst_n = 0;
  logic [4:0] opcode = 0;
  logic [1:0] functionCode = 0, branchFunc = 0;
  logic [3:0] NZCV = 0;
  logic memReady = 0, outAck = 0;
  logic memReq, irWrite, pcWrite, flagWrite, regWrite, writeMem, jal, mem2Reg, aluSrcB, outR, hlt;
  logic [1:0] pcSel;
  logic [2:0] aluOpcode, state;
  logic [3:0] retired;
  outs_t obs;
  ent_t q[$];
  int total = 0, bad = 0, done = 0;
  assign obs = {memReq, irWrite, pcWrite, flagWrite, pcSel, regWrite, writeMem, jal, mem2Reg,
                aluSrcB, aluOpcode, outR, hlt};
  always #5 clk = ~clk;
  multicycle_controller #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .functionCode(functionCode),
    .branchFunc(branchFunc), .NZCV(NZCV), .memReady(memReady), .outAck(outAck),
    .memReq(memReq), .irWrite(irWrite), .pcWrite(pcWrite), .flagWrite(flagWrite),
    .pcSel(pcSel), .regWrite(regWrite), .writeMem(writeMem), .jal(jal), .mem2Reg(mem2Reg),
    .aluSrcB(aluSrcB), .aluOpcode(aluOpcode), .outR(outR), .hlt(hlt), .state(state)
`ifdef RETIRE_CNT_EN
    , .retired(retired)
`endif
  );
`ifndef RETIRE_CNT_EN
  assign retired = '0;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  function automatic void push(input logic mr, input logic ack, input logic [2:0] st, input outs_t o);
    ent_t e;
    e.mr = mr;
    e.ack = ack;
    e.st = st;
    e.o = o;
    e.ret = 4'(done % 16);
    q.push_back(e);
  endfunction
  function automatic logic alu_class(input logic [4:0] op, input logic [1:0] fc,
                                     output logic [2:0] alu, output logic b, output logic fl);
    alu = 0;
    b = 0;
    fl = 0;
    alu_class = 1;
    case (op)
      5'b00000: begin alu = 3'd2 + 3'(fc); fl = 1; end
      5'b00100: begin alu = 2; b = 1; fl = 1; end
      5'b00101: begin alu = 4; b = 1; fl = 1; end
      5'b00110: alu = 6;
      5'b01000: begin alu = 0; b = 1; end
      5'b01001: begin alu = 1; b = 1; end
      default: alu_class = 0;
    endcase
  endfunction
  task automatic plan(input logic [4:0] op, input logic [1:0] fc, input logic [1:0] bf,
                      input logic [3:0] f, input int fw, input int mw, input int aw);
    outs_t o;
    logic [2:0] alu;
    logic b, fl, tk, halted;
    halted = 0;
    o = '0;
    o.mem_req = 1;
    repeat (fw) push(0, 0, S_F, o);
    o.ir_write = 1;
    o.pc_write = 1;
    push(1, 0, S_F, o);
    o = '0;
    push(rb(), 0, S_D, o);
    if (alu_class(op, fc, alu, b, fl)) begin
      o.alu_op = alu;
      o.alu_b = b;
      o.flag_write = fl;
      push(rb(), 0, S_E, o);
      o.flag_write = 0;
      o.reg_write = 1;
      push(rb(), 0, S_W, o);
    end else case (op)
      5'b00001: begin o.alu_op = 4; o.flag_write = 1; push(rb(), 0, S_E, o); end
      LDR, STR: begin
        o.alu_b = 1;
        o.alu_op = 2;
        push(rb(), 0, S_E, o);
        o.mem_req = 1;
        o.write_mem = op == STR;
        repeat (mw) push(0, 0, S_M, o);
        push(1, 0, S_M, o);
        if (op == LDR) begin
          o.mem_req = 0;
          o.reg_write = 1;
          o.mem2reg = 1;
          push(rb(), 0, S_W, o);
        end
      end
      BCC, BAL: begin
        tk = op == BAL || (bf == 0 ? f[2] : bf == 1 ? !f[2] : bf == 2 ? f[1] : !f[1]);
        if (tk) begin o.pc_write = 1; o.pc_sel = 1; o.alu_b = 1; end
        push(rb(), 0, S_E, o);
      end
      JMP: begin o.pc_write = 1; o.pc_sel = 2; push(rb(), 0, S_E, o); end
      JAL: begin o.jal = 1; o.reg_write = 1; o.alu_b = 1; o.pc_write = 1; o.pc_sel = 1; push(rb(), 0, S_E, o); end
      JALR: begin o.jal = 1; o.reg_write = 1; o.pc_write = 1; o.pc_sel = 3; push(rb(), 0, S_E, o); end
      JR: begin o.pc_write = 1; o.pc_sel = 3; push(rb(), 0, S_E, o); end
      SYS: begin
        push(rb(), 0, S_E, o);
        if (fc == 0) begin
          o.out_r = 1;
          repeat (aw) push(rb(), 0, S_O, o);
          push(rb(), 1, S_O, o);
        end else begin
          halted = 1;
          o.hlt = 1;
          repeat (100) push(rb(), rb(), S_H, o);
        end
      end
      default: push(rb(), 0, S_E, o);
    endcase
    if (!halted) done++;
  endtask
  task automatic run(input string tag, input int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e = q.pop_front();
      memReady = e.mr;
      outAck = e.ack;
      @(negedge clk);
      check({tag, "/state"}, 32'(state), 32'(e.st));
      check({tag, "/outs"}, 32'(obs), 32'(e.o));
`ifdef RETIRE_CNT_EN
      check({tag, "/retired"}, 32'(retired), 32'(e.ret));
`endif
      @(posedge clk);
      #1;
    end
  endtask
  task automatic instr(input string tag, input logic [4:0] op, input logic [1:0] fc, input logic [1:0] bf,
                       input logic [3:0] f, input int fw, input int mw, input int aw);
    opcode = op;
    functionCode = fc;
    branchFunc = bf;
    NZCV = f;
    plan(op, fc, bf, f, fw, mw, aw);
    run(tag, q.size());
  endtask
  task automatic do_reset();
    rst_n = 0;
    memReady = rb();
    @(posedge clk);
    #1;
    rst_n = 1;
    done = 0;
    push(rb(), 0, S_F, '0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog state=%0d", state);
    $fatal(1);
  end
  initial begin
    logic [4:0] ops[17];
    logic [4:0] op;
    logic [1:0] fc;
    ops = '{5'b00000, 5'b00001, 5'b00100, 5'b00101, 5'b00110, 5'b01000, 5'b01001, LDR, STR,
            BCC, BAL, JMP, JAL, SYS, JALR, JR, NOP};
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    push(rb(), 0, S_F, '0);
    instr("add", 5'b00000, 0, 0, 0, 0, 0, 0);
    instr("ldr", LDR, 0, 0, 0, 0, 3, 0);
    instr("str", STR, 0, 0, 0, 1, 2, 0);
    instr("beq_t", BCC, 0, 0, 4'b0100, 0, 0, 0);
    instr("beq_n", BCC, 0, 0, 4'b0000, 0, 0, 0);
    instr("out5", SYS, 0, 0, 0, 0, 0, 5);
    instr("out0", SYS, 0, 0, 0, 0, 0, 0);
    repeat (150) begin
      op = ops[$urandom_range(0, 16)];
      fc = op == SYS ? 2'd0 : 2'($urandom);
      instr("rand", op, fc, 2'($urandom), 4'($urandom), $urandom_range(0, 2),
            $urandom_range(0, 3), $urandom_range(0, 3));
    end
    do_reset();
    repeat (17) instr("nop", NOP, 0, 0, 0, 0, 0, 0);
`ifdef RETIRE_CNT_EN
    check("wrap", 32'(retired), 32'd1);
`endif
    instr("hlt", SYS, 2'b01, 0, 0, 0, 0, 0);
    do_reset();
    repeat (3) instr("nop2", NOP, 0, 0, 0, 0, 0, 0);
    opcode = LDR;
    plan(LDR, 0, 0, 0, 0, 10, 0);
    run("ldr_mem", 4);
    q.delete();
    do_reset();
    instr("after_rst", 5'b00000, 2'b10, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter LENGTH, default 16, datapath width passed through to the datapath; no effect on control timing.
REQ-002 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 SHALL have one clock; reset is synchronous and active-low. Ports: clk in 1, rising-edge clock; rst_n in 1, synchronous active-low reset.
REQ-004 SHALL have ports opcode in 5, functionCode in 2, branchFunc in 2, NZCV in 4; all are decode fields and flags, valid from DECODE onward.
REQ-005 SHALL have ports memReady in 1, memory ack; outAck in 1, output consumer ack.
REQ-006 SHALL have ports memReq out 1, irWrite out 1, pcWrite out 1, flagWrite out 1.
REQ-007 SHALL have ports pcSel out 2, regWrite out 1, writeMem out 1, jal out 1, mem2Reg out 1, aluSrcB out 1, aluOpcode out 3, outR out 1, hlt out 1, state out 3.
REQ-008 SHALL have port retired out CNT_W, present only with the macro (see Configuration).
REQ-009 SHALL use encodings as follows. aluOpcode: LHI0, LLI1, ADD2, ADC3, SUB4, SBB5, MOV6. pcSel: PLUS0, BRANCH1, LABEL2, RM3.

Function
REQ-010 SHALL implement a Moore/Mealy FSM with states FETCH0, DECODE1, EXEC2, MEM3, WB4, OUT5, HALT6; the state port shows the current state.
REQ-011 SHALL drive all outputs 0 in any state and condition not listed.
REQ-012 FETCH SHALL assert memReq. On memReady it SHALL pulse irWrite and pcWrite with pcSel=PLUS, then go to DECODE; otherwise it SHALL hold FETCH.
REQ-013 DECODE SHALL assert no outputs and always go to EXEC.
REQ-014 EXEC for ALU ops (opcode 00000, LHI, LLI, ADDI, SUBI, MOV) SHALL drive aluOpcode and aluSrcB per opcode, then go to WB.
REQ-015 EXEC SHALL assert flagWrite for ADD/ADC/SUB/SBB/ADDI/SUBI/CMP.
REQ-016 EXEC for CMP SHALL set aluOpcode=SUB and flagWrite=1, then go to FETCH.
REQ-017 EXEC for LDR/STR SHALL set aluSrcB=1 and aluOpcode=ADD, then go to MEM.
REQ-018 MEM SHALL hold memReq, aluSrcB and aluOpcode=ADD, plus writeMem for STR, until memReady. On memReady, LDR SHALL go to WB and STR SHALL go to FETCH.
REQ-019 WB SHALL assert regWrite for one cycle, with mem2Reg=1 for LDR and the EXEC aluOpcode/aluSrcB held; it SHALL then go to FETCH.
REQ-020 EXEC branches SHALL behave as follows. Conditional branch 11000: BEQ taken on Z (NZCV[2]), BNE on !Z, BCS on C (NZCV[1]), BCC on !C. B[AL] 11001 is always taken. Taken SHALL give pcWrite=1, pcSel=BRANCH, aluSrcB=1. All branches SHALL then go to FETCH.
REQ-021 EXEC jump/link SHALL behave as follows. JMP: pcWrite, pcSel=LABEL. JAL label: jal, regWrite, aluSrcB, pcWrite, pcSel=BRANCH. JAL Rd Rm: jal, regWrite, pcWrite, pcSel=RM. JR: pcWrite, pcSel=RM. The link write and the PC write SHALL occur in the same edge, then go to FETCH.
REQ-022 EXEC for 11100 with functionCode=00 SHALL go to OUT; any other functionCode SHALL go to HALT.
REQ-023 OUT SHALL hold outR=1 until outAck, with outR dropping the cycle after ack, then go to FETCH; an outAck already high on OUT entry SHALL complete in 1 cycle.
REQ-024 HALT SHALL assert hlt permanently and ignore all inputs until reset.
REQ-025 An undefined opcode in EXEC SHALL be a NOP and go to FETCH.
REQ-026 Latency with memReady tied high SHALL be: ALU 4 cycles, LDR 5, STR 4, branch/jump/CMP 3, OutR 4 with immediate ack.
REQ-027 memReady outside FETCH/MEM SHALL be ignored.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force state=FETCH from any state, including MEM mid-handshake and HALT.
REQ-029 All registered outputs SHALL be 0 after reset, with retired=0.
REQ-030 The first FETCH after reset SHALL raise memReq in the cycle following rst_n release.

Configuration
REQ-031 With RETIRE_CNT_EN defined, retired SHALL increment, wrapping modulo 2^CNT_W, on every transition into FETCH from EXEC/MEM/WB/OUT, and SHALL never count HALT.
REQ-032 Without RETIRE_CNT_EN, the retired port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then ADD (00000/00) with memReady=1 -> state sequence 0,1,2,4,0; regWrite high only in WB; flagWrite high in EXEC; aluOpcode=2.
REQ-034 LDR with memReady low for 3 MEM cycles -> memReq held 4 cycles in MEM, then WB with mem2Reg=1 and regWrite=1; total 8 cycles.
REQ-035 BEQ with NZCV=4'b0100 -> pcWrite=1, pcSel=1 in EXEC; with NZCV=0 -> pcWrite=0; both return to FETCH.
REQ-036 OutR with outAck asserted 5 cycles after OUT entry -> outR high 6 cycles; HLT -> hlt stays 1 for 100 cycles; rst_n low 1 edge -> state=0, hlt=0.
REQ-037 RETIRE_CNT_EN with CNT_W=4: 17 NOPs -> retired=1 (wrap); rst_n pulse in MEM -> memReq=0 next cycle, retired=0.
